// File: rtl/nand_op_sequencer.sv
// Multi-function bitwise logic unit built from one shared WIDTH-bit NAND gate.
// A per-opcode micro-sequence drives the gate once per cycle through scratch registers T and U.
module nand_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       nand_count
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {SRC_A, SRC_B, SRC_T, SRC_U} src_t;
    typedef enum logic [1:0] {DST_T, DST_U, DST_R} dst_t;

    typedef struct packed {
        src_t x;
        src_t y;
        dst_t dst;
    } uop_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;

    logic [2:0]       r_op;
    logic [2:0]       r_step;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_u;
    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_count;

    uop_t             w_uop;
    logic             w_last;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_nand;

    function automatic uop_t mk(input src_t x, input src_t y, input dst_t d);
        uop_t u;
        u.x   = x;
        u.y   = y;
        u.dst = d;
        return u;
    endfunction

    function automatic logic [WIDTH-1:0] pick(input src_t s,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] t,
                                              input logic [WIDTH-1:0] u);
        case (s)
            SRC_A:   return a;
            SRC_B:   return b;
            SRC_T:   return t;
            default: return u;
        endcase
    endfunction

    // Micro-program ROM: the step that targets R is the final one of each sequence.
    always_comb begin
        w_uop = mk(SRC_A, SRC_B, DST_R);
        case (r_op)
            3'd0: w_uop = mk(SRC_A, SRC_B, DST_R);
            3'd1: begin
                case (r_step)
                    3'd0:    w_uop = mk(SRC_A, SRC_B, DST_T);
                    default: w_uop = mk(SRC_T, SRC_T, DST_R);
                endcase
            end
            3'd2: begin
                case (r_step)
                    3'd0:    w_uop = mk(SRC_A, SRC_A, DST_T);
                    3'd1:    w_uop = mk(SRC_B, SRC_B, DST_U);
                    default: w_uop = mk(SRC_T, SRC_U, DST_R);
                endcase
            end
            3'd3: begin
                case (r_step)
                    3'd0:    w_uop = mk(SRC_A, SRC_A, DST_T);
                    3'd1:    w_uop = mk(SRC_B, SRC_B, DST_U);
                    3'd2:    w_uop = mk(SRC_T, SRC_U, DST_T);
                    default: w_uop = mk(SRC_T, SRC_T, DST_R);
                endcase
            end
            3'd4: begin
                case (r_step)
                    3'd0:    w_uop = mk(SRC_A, SRC_B, DST_T);
                    3'd1:    w_uop = mk(SRC_A, SRC_T, DST_U);
                    3'd2:    w_uop = mk(SRC_B, SRC_T, DST_T);
                    default: w_uop = mk(SRC_U, SRC_T, DST_R);
                endcase
            end
            3'd5: begin
                case (r_step)
                    3'd0:    w_uop = mk(SRC_A, SRC_B, DST_T);
                    3'd1:    w_uop = mk(SRC_A, SRC_T, DST_U);
                    3'd2:    w_uop = mk(SRC_B, SRC_T, DST_T);
                    3'd3:    w_uop = mk(SRC_U, SRC_T, DST_T);
                    default: w_uop = mk(SRC_T, SRC_T, DST_R);
                endcase
            end
            3'd6: w_uop = mk(SRC_A, SRC_A, DST_R);
            default: begin
                case (r_step)
                    3'd0:    w_uop = mk(SRC_A, SRC_A, DST_T);
                    default: w_uop = mk(SRC_T, SRC_T, DST_R);
                endcase
            end
        endcase
    end

    assign w_last = (w_uop.dst == DST_R);

    // The single shared NAND unit; operands come only from registered state.
    assign w_x    = pick(w_uop.x, r_a, r_b, r_t, r_u);
    assign w_y    = pick(w_uop.y, r_a, r_b, r_t, r_u);
    assign w_nand = ~(w_x & w_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_EXEC;
                    w_accept     = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_next = S_EXEC;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_step  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_t     <= '0;
            r_u     <= '0;
            r_out   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_op   <= op;
            r_a    <= in_a;
            r_b    <= in_b;
            r_step <= '0;
        end else if (r_state == S_EXEC) begin
            r_step <= r_step + 3'd1;
            case (w_uop.dst)
                DST_T: r_t <= w_nand;
                DST_U: r_u <= w_nand;
                default: begin
                    r_out   <= w_nand;
                    r_count <= r_step + 3'd1;
                end
            endcase
        end
    end

    assign busy       = (r_state == S_EXEC);
    assign done       = (r_state == S_DONE);
    assign out        = r_out;
    assign nand_count = r_count;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed self-checking bench for nand_op_sequencer at WIDTH=4 and WIDTH=1.
module tb_nand_op_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       busy;
    logic       done;
    logic [3:0] out;
    logic [2:0] nand_count;

    logic       start1;
    logic [2:0] op1;
    logic       a1;
    logic       b1;
    logic       busy1;
    logic       done1;
    logic       out1;
    logic [2:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    nand_op_sequencer #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .in_a       (in_a),
        .in_b       (in_b),
        .busy       (busy),
        .done       (done),
        .out        (out),
        .nand_count (nand_count)
    );

    nand_op_sequencer #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .op         (op1),
        .in_a       (a1),
        .in_b       (b1),
        .busy       (busy1),
        .done       (done1),
        .out        (out1),
        .nand_count (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one operation from IDLE on the WIDTH=4 instance and check latency and result.
    task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_out, input int exp_n);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0; in_a = 4'hx; in_b = 4'hx;
        check("busy_after_start", busy, 1'b1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, exp_n);
        check("out", out, exp_out);
        check("nand_count", nand_count, exp_n);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_idle", busy, 1'b0);
    endtask

    function automatic logic ref_fn(input logic [2:0] o, input logic a, input logic b);
        case (o)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic int ref_n(input logic [2:0] o);
        case (o)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 3;
            3'd3:    return 4;
            3'd4:    return 4;
            3'd5:    return 5;
            3'd6:    return 1;
            default: return 2;
        endcase
    endfunction

    task automatic run_w1(input logic [2:0] o, input logic a, input logic b);
        int cyc;
        @(negedge clk);
        start1 = 1'b1; op1 = o; a1 = a; b1 = b;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w1_latency", cyc, ref_n(o));
        check("w1_out", out1, ref_fn(o, a, b));
        check("w1_count", cnt1, ref_n(o));
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; op = '0; in_a = '0; in_b = '0;
        start1 = 1'b0; op1 = '0; a1 = 1'b0; b1 = 1'b0;

        // 1: reset and idle
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_out", out, 4'b0000);
            check("idle_count", nand_count, 3'd0);
        end

        // 2: all opcodes on 1100 / 1010
        run_op(3'd0, 4'b1100, 4'b1010, 4'b0111, 1);
        run_op(3'd1, 4'b1100, 4'b1010, 4'b1000, 2);
        run_op(3'd2, 4'b1100, 4'b1010, 4'b1110, 3);
        run_op(3'd3, 4'b1100, 4'b1010, 4'b0001, 4);
        run_op(3'd4, 4'b1100, 4'b1010, 4'b0110, 4);
        run_op(3'd5, 4'b1100, 4'b1010, 4'b1001, 5);
        run_op(3'd6, 4'b1100, 4'b1010, 4'b0011, 1);
        run_op(3'd7, 4'b1100, 4'b1010, 4'b1100, 2);

        // 3: start while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd5; in_a = 4'b1100; in_b = 4'b1010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; in_a = 4'b1111; in_b = 4'b1111;
        check("busy_2nd_cycle", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ignored_latency", cyc, 5);
        check("ignored_out", out, 4'b1001);
        check("ignored_count", nand_count, 3'd5);
        @(negedge clk);
        check("ignored_no_second_done", done, 1'b0);
        check("ignored_not_busy", busy, 1'b0);

        // 4: back-to-back AND then OR
        @(negedge clk);
        start = 1'b1; op = 3'd1; in_a = 4'b1111; in_b = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", cyc, 2);
        check("b2b_first_out", out, 4'b0101);
        start = 1'b1; op = 3'd2; in_a = 4'b0000; in_b = 4'b0011;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next", busy, 1'b1);
        check("b2b_done_dropped", done, 1'b0);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_latency", cyc, 3);
        check("b2b_second_out", out, 4'b0011);
        check("b2b_second_count", nand_count, 3'd3);

        // 5: reset mid-operation
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd4; in_a = 4'b1100; in_b = 4'b1010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy_before", busy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out", out, 4'b0000);
        check("abort_count", nand_count, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        run_op(3'd0, 4'b0000, 4'b0000, 4'b1111, 1);

        // 6: WIDTH=1 exhaustive
        for (int o = 0; o < 8; o++) begin
            for (int v = 0; v < 4; v++) begin
                run_w1(3'(o), v[1], v[0]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
